// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer sharing one fixed-latency data-memory port between fetch and load/store.
// Optional starvation guard for fetch: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // The wait counter and the starvation counter are both 4 bits wide.
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  logic [1:0]        r_state;
  logic              r_owner_d;
  logic [3:0]        r_cnt;
  logic              r_mem_we;
  logic [2:0]        r_mem_funct3;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_idle;
  logic w_force_if;
  logic w_d_gnt;
  logic w_if_gnt;

  // Grants are gated by reset so every output reads 0 while reset is held.
  assign w_idle   = (r_state == S_IDLE) && reset;
  assign w_d_gnt  = w_idle && d_req && !w_force_if;
  assign w_if_gnt = w_idle && if_req && !w_d_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] r_starve;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= 4'd0;
    end else if (w_if_gnt) begin
      r_starve <= 4'd0;
    end else if (w_d_gnt) begin
      r_starve <= if_req ? r_starve + 4'd1 : 4'd0;
    end
  end

  assign w_force_if = (r_starve == 4'(STARVE_MAX)) && if_req && d_req;
`else
  assign w_force_if = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_owner_d    <= 1'b0;
      r_cnt        <= 4'd0;
      r_mem_we     <= 1'b0;
      r_mem_funct3 <= 3'b000;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_d_gnt) begin
            r_mem_we     <= d_we;
            r_mem_funct3 <= d_funct3;
            r_mem_addr   <= d_addr;
            r_mem_wdata  <= d_wdata;
            r_owner_d    <= 1'b1;
            r_state      <= S_ISSUE;
          end else if (w_if_gnt) begin
            // Fetches are always word reads; write data is left as it was.
            r_mem_we     <= 1'b0;
            r_mem_funct3 <= 3'b010;
            r_mem_addr   <= if_addr;
            r_owner_d    <= 1'b0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= 4'(MEM_LAT);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            if (!r_owner_d) begin
              r_if_rdata <= mem_rdata;
            end else if (!r_mem_we) begin
              r_d_rdata <= mem_rdata;
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_gnt     = w_if_gnt;
  assign d_gnt      = w_d_gnt;
  assign mem_en     = (r_state == S_ISSUE);
  assign busy       = (r_state != S_IDLE);
  assign if_rvalid  = (r_state == S_RESP) && !r_owner_d;
  assign d_rvalid   = (r_state == S_RESP) && r_owner_d;
  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;
  assign mem_we     = r_mem_we;
  assign mem_funct3 = r_mem_funct3;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard of responses, and corner-case sequences.
// Honours MEM_ARB_STARVE_GUARD_EN for the expected grant pattern under contention.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [2:0]    d_funct3 = 3'b000;
  logic [DW-1:0] d_wdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;

  // Second instance for the single-cycle-latency regression.
  logic          l1_if_req = 1'b0;
  logic [AW-1:0] l1_if_addr = '0;
  logic          l1_if_gnt, l1_if_rvalid, l1_d_gnt, l1_d_rvalid, l1_mem_en, l1_mem_we, l1_busy;
  logic [DW-1:0] l1_if_rdata, l1_d_rdata, l1_mem_wdata, l1_mem_rdata;
  logic [2:0]    l1_mem_funct3;
  logic [AW-1:0] l1_mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid),
    .if_rdata(l1_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_funct3(3'b000), .d_addr('0), .d_wdata('0),
    .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_funct3(l1_mem_funct3), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Memory model: data is valid only MEM_LAT cycles after the mem_en cycle.
  logic [7:0] pipe, l1_pipe;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe    <= '0;
      l1_pipe <= '0;
    end else begin
      pipe    <= {pipe[6:0], mem_en};
      l1_pipe <= {l1_pipe[6:0], l1_mem_en};
    end
  end
  assign mem_rdata    = pipe[LAT-1] ? word(mem_addr) : 32'hDEAD_BEEF;
  assign l1_mem_rdata = l1_pipe[0] ? word(l1_mem_addr) : 32'hDEAD_BEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && (if_rvalid || d_rvalid)) begin
      if (sb.size() == 0) begin
        check("spurious_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rvalid_port", {if_rvalid, d_rvalid}, mon_e.is_d ? 2'b01 : 2'b10);
        check("rvalid_cycle", cyc, mon_e.cyc);
        check("rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
      end
    end
  end

  logic [31:0] d_last = '0;
  int          last_t = 0;

  task automatic await_grant(input bit exp_d, input int exp_cyc, input logic [31:0] ea,
                             input bit ewe, input logic [2:0] ef3, input bit chk_wd,
                             input logic [31:0] ewd, input logic [31:0] erd);
    bit got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        got = 1'b1;
        break;
      end
    end
    check("gnt_seen", got, 1);
    if (!got) return;
    check("gnt_owner", {d_gnt, if_gnt}, exp_d ? 2'b10 : 2'b01);
    if (exp_cyc >= 0) check("gnt_cycle", cyc, exp_cyc);
    last_t = cyc;
    sb.push_back('{exp_d, erd, cyc + 2 + LAT});
    @(posedge clk);
    #1;
    if (exp_d) d_req = 1'b0;
    else       if_req = 1'b0;
    @(negedge clk);
    check("issue_mem_en", mem_en, 1);
    check("issue_busy", busy, 1);
    check("issue_addr", mem_addr, ea);
    check("issue_we", mem_we, ewe);
    check("issue_funct3", mem_funct3, ef3);
    if (chk_wd) check("issue_wdata", mem_wdata, ewd);
    @(negedge clk);
    check("mem_en_one_cycle", mem_en, 0);
    check("addr_held", mem_addr, ea);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_reached", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {if_gnt, d_gnt}, 0);
    check({tag, "_rvalid"}, {if_rvalid, d_rvalid}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_ctl"}, {mem_en, mem_we, mem_funct3}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  typedef struct {
    bit          ir, dr, we;
    logic [2:0]  f3;
    logic [31:0] ia, da, wd;
  } vec_t;
  vec_t tbl[6];

  bit guard_on;
  bit exp_d;
  int prev, n_ig, n_en, t1;
  bit got1;

  initial begin
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    tbl[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0,        32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h100,      32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0,         32'h3FC,      32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 3'b000, 32'h0,         32'h204,      32'hAB};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFC, 32'h0,        32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 3'b001, 32'h0000_0040, 32'h0000_0008, 32'h1234};

    // Reset with both requests raised: every output must still read 0.
    if_req = 1'b1;
    d_req  = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      if_req = tbl[i].ir; if_addr = tbl[i].ia;
      d_req = tbl[i].dr; d_we = tbl[i].we; d_funct3 = tbl[i].f3;
      d_addr = tbl[i].da; d_wdata = tbl[i].wd;
      if (tbl[i].dr) begin
        await_grant(1'b1, -1, tbl[i].da, tbl[i].we, tbl[i].f3, 1'b1, tbl[i].wd,
                    tbl[i].we ? d_last : word(tbl[i].da));
        if (!tbl[i].we) d_last = word(tbl[i].da);
        if (tbl[i].ir)
          await_grant(1'b0, last_t + LAT + 3, tbl[i].ia, 1'b0, 3'b010, 1'b0, '0, word(tbl[i].ia));
      end else begin
        await_grant(1'b0, -1, tbl[i].ia, 1'b0, 3'b010, 1'b0, '0, word(tbl[i].ia));
      end
      wait_idle();
    end

    // Both requests held continuously: grant pattern depends on the starvation guard.
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h180;
    if_req = 1'b1; if_addr = 32'h80;
    prev = 0;
    for (int g = 0; g < 10; g++) begin
      got1 = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (if_gnt || d_gnt) begin
          got1 = 1'b1;
          break;
        end
      end
      check("guard_gnt_seen", got1, 1);
      exp_d = guard_on ? (g % 5 != 4) : 1'b1;
      check("guard_owner", {d_gnt, if_gnt}, exp_d ? 2'b10 : 2'b01);
      if (g > 0) check("guard_spacing", cyc - prev, LAT + 3);
      prev = cyc;
      sb.push_back('{exp_d, exp_d ? word(32'h180) : word(32'h80), cyc + 2 + LAT});
      if (exp_d) d_last = word(32'h180);
    end
    @(posedge clk);
    #1;
    d_req  = 1'b0;
    if_req = 1'b0;
    wait_idle();

    // Reset during WAIT abandons the access.
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h50;
    await_grant(1'b0, -1, 32'h50, 1'b0, 3'b010, 1'b0, '0, word(32'h50));
    #1;
    reset = 1'b0;
    sb.delete();
    d_last = '0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_reset_quiet", {busy, if_rvalid, d_rvalid}, 0);
    end
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b100; d_addr = 32'h44;
    await_grant(1'b1, -1, 32'h44, 1'b0, 3'b100, 1'b1, d_wdata, word(32'h44));
    d_last = word(32'h44);
    wait_idle();

    // Fetch request withdrawn while a data access is in flight.
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h60;
    await_grant(1'b1, -1, 32'h300, 1'b0, 3'b010, 1'b1, d_wdata, word(32'h300));
    d_last = word(32'h300);
    #1;
    if_req = 1'b0;
    n_ig = 0;
    n_en = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_ig += int'(if_gnt);
      n_en += int'(mem_en);
    end
    check("dropped_fetch_gnt", n_ig, 0);
    check("dropped_fetch_mem_en", n_en, 0);
    wait_idle();

    // MEM_LAT=1 instance: rvalid three cycles after the grant.
    @(posedge clk);
    #1;
    l1_if_req = 1'b1; l1_if_addr = 32'h24;
    got1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (l1_if_gnt) begin
        got1 = 1'b1;
        break;
      end
    end
    check("l1_gnt_seen", got1, 1);
    t1 = cyc;
    @(posedge clk);
    #1;
    l1_if_req = 1'b0;
    got1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (l1_if_rvalid) begin
        got1 = 1'b1;
        break;
      end
    end
    check("l1_rvalid_seen", got1, 1);
    check("l1_rvalid_latency", cyc - t1, 3);
    check("l1_rdata", l1_if_rdata, word(32'h24));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the core's single-port data memory. It shares one memory port between the instruction-fetch path and the load/store path. It sequences each access through issue, fixed-latency wait and response phases. Load/store has priority over fetch, with an optional starvation guard. It sits between the ProgramCounter/fetch logic and the load/store datapath on one side and DataMemory on the other.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1–15
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (guard only)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted (1-cycle pulse)
- `if_rvalid`  out  1  fetch data valid (1-cycle pulse)
- `if_rdata`  out  DATA_W  fetched instruction
- `d_req`  in  1  load/store request
- `d_we`  in  1  1 = store
- `d_funct3`  in  3  access size/sign, passed to memory
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data accepted (1-cycle pulse)
- `d_rvalid`  out  1  load data valid or store complete (1-cycle pulse)
- `d_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_funct3`  out  3  memory access size
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: evaluate requests each cycle.
  - If `d_req` is high, assert `d_gnt`; otherwise, if `if_req` is high, assert `if_gnt`.
  - `gnt` is combinational from the state and the requests.
  - On the edge ending the grant cycle, register the address, `we`, `funct3` and `wdata` into the `mem_*` outputs, record the owner, and go to ISSUE.
  - Fetch accesses drive `mem_we`=0 and `mem_funct3`=3'b010.
- ISSUE: `mem_en`=1 for exactly this cycle. Load the wait counter with `MEM_LAT`, then go to WAIT.
- WAIT: decrement the counter every cycle. In the cycle where the counter equals 1, capture `mem_rdata` into the owner's rdata register, then go to RESP.
- RESP: pulse the owner's `rvalid`, then go to IDLE. No grant is issued in RESP.
- Stores still pulse `d_rvalid`. `d_rdata` is not updated by a store.
- `if_rdata` and `d_rdata` hold their last value until the next completed read for that port.
- The `mem_*` address/data outputs hold their values outside ISSUE; only `mem_en` is strobed.
- Requesters hold `req` and their payload until `gnt`. Dropping `req` before `gnt` is legal and issues nothing.
- A request asserted outside IDLE waits; it is never lost while held.

## Timing
- Reset (async, `reset`=0): state=IDLE, and all outputs are 0 (`gnt`, `rvalid`, `rdata`, all `mem_*`, `busy`). The starvation counter is 0.
- Reset asserted mid-transaction abandons the access. No `rvalid` is produced.
- Grant in cycle t leads to `mem_en` in t+1, capture in t+1+`MEM_LAT`, and `rvalid` in t+2+`MEM_LAT`. The earliest next grant is t+3+`MEM_LAT`.
- With `MEM_LAT`=2, a grant in cycle 0 gives `rvalid` in cycle 4 and the next grant in cycle 5.
- Both requests arriving in the same IDLE cycle: data wins unless the guard forces fetch.
- `busy` is 1 in ISSUE, WAIT and RESP.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each `d_gnt` issued while `if_req`=1.
  - It clears on each `if_gnt`, and also clears when a data grant is issued with `if_req`=0.
  - When the counter equals `STARVE_MAX` and both requests are present, fetch wins.
- Not defined: strict data priority; fetch can starve indefinitely. The counter logic is absent.

## Test plan
- Reset then idle: all outputs 0. Assert `if_req` with `if_addr`=0x10 and `MEM_LAT`=2. Expect `if_gnt` in cycle 0, `mem_en`/`mem_addr`=0x10 in cycle 1, and `if_rvalid` with `if_rdata`=mem word in cycle 4.
- Simultaneous `if_req` and `d_req` (load from 0x100) → `d_gnt` first, load data returned. The fetch grant follows exactly `MEM_LAT`+3 cycles later.
- Store with `d_we`=1, `d_funct3`=3'b000, `d_addr`=0x204, `d_wdata`=0xAB → one `mem_en` cycle with `mem_we`=1 and the matching fields. `d_rvalid` pulses; `d_rdata` is unchanged.
- Guard enabled, `STARVE_MAX`=4, both requests held continuously → grant sequence D,D,D,D,I,D,D,D,D,I. Guard disabled → D only.
- Drive `reset` low during WAIT → state returns to IDLE immediately, with no `rvalid` and all outputs 0. After release, a new request completes normally.
- Drop `if_req` while a data access is busy → no fetch is issued afterward. `MEM_LAT`=1 regression: `rvalid` arrives 3 cycles after the grant.
